sar_scan_sequencer: RTL and testbench
=====================================

# sar_scan_sequencer

Round-robin scan controller for the 3-bit SAR ADC core. Selects an enabled input channel, holds it through a settle window, pulses the core's `reset` input to start a conversion, and waits for `done`. It then captures `sel_wire` as the result and presents it with channel tag on a valid/ready port. Sits between the analog input mux / sample switch and the digital result consumer.

## Interface
- `NUM_CH`, 4, number of analog input channels (2..8)
- `CH_W`, 2, width of channel index, clog2(NUM_CH)
- `RES_W`, 3, conversion result width (matches core `sel_wire`)
- `SETTLE_CYCLES`, 4, cycles `sample` is held high before each conversion (>=1)
- `TIMEOUT_CYCLES`, 16, max CONVERT cycles before abort (>=4)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `enable`  in  1  scan enable; level-sensitive
- `ch_mask`  in  NUM_CH  per-channel enable; bit i = channel i
- `clr_err`  in  1  one-cycle pulse, clears sticky error flags
- `ch_sel`  out  CH_W  analog mux select
- `sample`  out  1  sample switch closed (track) when 1
- `adc_start`  out  1  one-cycle pulse to core `reset` (core loads midscale 3'b011)
- `adc_done`  in  1  core `done`
- `adc_code`  in  RES_W  core `sel_wire`
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_code`  out  RES_W  captured conversion code
- `res_ch`  out  CH_W  channel of `res_code`
- `busy`  out  1  state != IDLE
- `overrun`  out  1  sticky: result dropped, output register full
- `timeout_err`  out  1  sticky: conversion aborted, no `adc_done`

## Operation
- States: IDLE, SETTLE, START, CONVERT, STORE.
- Channel pick: next set bit of `ch_mask` strictly after `last_ch`, wrapping modulo NUM_CH. `last_ch` resets to NUM_CH-1, so the first pick after reset is the lowest enabled channel. A single enabled channel repeats. `ch_mask` is evaluated only at a pick.
- IDLE: if `enable` and `ch_mask` != 0, pick channel, load `ch_sel`, `last_ch`, settle counter = SETTLE_CYCLES-1, go SETTLE. Otherwise stay.
- SETTLE: `sample`=1. Count down; at 0 go START.
- START: `sample`=0, `adc_start`=1 for exactly this cycle. Go CONVERT, conv_cnt=0.
- CONVERT: conv_cnt increments each cycle.
  - `adc_done` is ignored while conv_cnt==0 (blanking: core `done` is stale before its midscale load).
  - When conv_cnt>=1 and `adc_done`=1: capture `adc_code` into the pending register and go STORE.
  - When conv_cnt==TIMEOUT_CYCLES-1 with no done: set `timeout_err`, discard, and go to pick-next logic (same as STORE exit).
- STORE:
  - If `res_valid`=0, or `res_valid & res_ready` this cycle: load `res_code`/`res_ch` and set `res_valid`.
  - Otherwise set `overrun`, drop the new result, and keep the old result unchanged.
- Exit (STORE/timeout): if `enable` and `ch_mask` != 0, pick next channel and go SETTLE directly. Otherwise go IDLE.
- `enable` deassert mid-scan: the current conversion completes through STORE, then IDLE. No abort.
- Output port: `res_valid` stays high until a cycle with `res_ready`=1. `res_code`/`res_ch` are stable while `res_valid`=1. A pop with no concurrent load clears `res_valid`.
- Sticky flags: cleared by `clr_err`. If a set and `clr_err` occur in the same cycle, set wins.
- Reset (`reset_n`=0 at an edge, from any state): state IDLE; `ch_sel`, `sample`, `adc_start`, `res_valid`, `res_code`, `res_ch`, `busy`, `overrun`, `timeout_err` all 0; `last_ch`=NUM_CH-1. A conversion in flight is discarded.

## Timing
- All outputs are registered except `busy`, which is decoded from the state register.
- Latency: call E0 the edge that samples `enable` in IDLE. SETTLE occupies the next SETTLE_CYCLES cycles, then START takes 1 cycle. If done is seen at CONVERT conv_cnt=k, STORE follows, and `res_valid` rises after edge E0+SETTLE_CYCLES+k+3.
- Conversions with the 3-bit core take k=2 or 3.
- Back-to-back scan period is SETTLE_CYCLES+k+3 cycles per channel.
- `ch_sel` changes only on the edge entering SETTLE, and never while `sample`=0 within a conversion.
- `adc_start` is never asserted in two consecutive cycles.

## Test plan
- Reset then `enable`=1, `ch_mask`=4'b1111, `res_ready`=1, core model converging at k=2 → results on channels 0,1,2,3,0 in order. First `res_valid` at E0+9, then one result every 9 cycles. `adc_start` is a 1-cycle pulse each time.
- `ch_mask`=4'b0100 → every `res_ch`=2. Change mask to 4'b1001 mid-SETTLE → current conversion stays on ch2, then next picks are 3, 0, 3.
- `res_ready`=0 for 3 conversions → first result held unchanged; `overrun`=1 after second STORE. `clr_err` pulse coincident with third STORE → `overrun` remains 1.
- `adc_done` held 0 (and held 1 during START/blanking) → `timeout_err`=1 at conv_cnt=15. No `res_valid`. Scan proceeds to next channel.
- `enable` dropped during CONVERT → that result is delivered, then `busy`=0 and IDLE. `ch_mask`=0 with `enable`=1 → stays IDLE, `sample`=0.
- `reset_n`=0 for one edge during CONVERT → all outputs 0 next cycle. Re-enable → first pick is the lowest enabled channel.

Source files
------------

// File: rtl/sar_scan_sequencer.sv
// Round-robin scan controller for the 3-bit SAR ADC core. It settles, starts and
// times out each conversion, then presents the code with its channel tag on a valid/ready port.
module sar_scan_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int RES_W          = 3,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              clr_err,
    output logic [CH_W-1:0]   ch_sel,
    output logic              sample,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [RES_W-1:0]  adc_code,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_code,
    output logic [CH_W-1:0]   res_ch,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CCW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, SETTLE, START, CONVERT, STORE} state_t;

    state_t           state, state_nxt;
    logic [CH_W-1:0]  last_ch, pick_ch, cand;
    logic [SCW-1:0]   settle_cnt;
    logic [CCW-1:0]   conv_cnt;
    logic [RES_W-1:0] pend_code;
    logic             can_scan, take_pick, capture, to_set, leave, store_load, pop;

    assign busy     = (state != IDLE);
    assign can_scan = enable && (ch_mask != '0);

    // Next enabled channel strictly after last_ch; the lowest offset wins.
    always_comb begin
        pick_ch = last_ch;
        cand    = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = CH_W'((int'(last_ch) + i) % NUM_CH);
            if (ch_mask[cand]) pick_ch = cand;
        end
    end

    always_comb begin
        state_nxt = state;
        take_pick = 1'b0;
        capture   = 1'b0;
        to_set    = 1'b0;
        leave     = 1'b0;
        case (state)
            IDLE: begin
                if (can_scan) begin
                    take_pick = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE:  if (settle_cnt == '0) state_nxt = START;
            START:   state_nxt = CONVERT;
            CONVERT: begin
                // conv_cnt==0 is blanked: the core's done is still from the last conversion
                if (conv_cnt != '0 && adc_done) begin
                    capture   = 1'b1;
                    state_nxt = STORE;
                end else if (conv_cnt == CCW'(TIMEOUT_CYCLES - 1)) begin
                    to_set = 1'b1;
                    leave  = 1'b1;
                end
            end
            STORE:   leave = 1'b1;
            default: state_nxt = IDLE;
        endcase
        if (leave) begin
            if (can_scan) begin
                take_pick = 1'b1;
                state_nxt = SETTLE;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    assign pop        = res_valid && res_ready;
    assign store_load = (state == STORE) && (!res_valid || pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            ch_sel      <= '0;
            last_ch     <= CH_W'(NUM_CH - 1);
            settle_cnt  <= '0;
            conv_cnt    <= '0;
            pend_code   <= '0;
            sample      <= 1'b0;
            adc_start   <= 1'b0;
            res_valid   <= 1'b0;
            res_code    <= '0;
            res_ch      <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            sample    <= (state_nxt == SETTLE);
            adc_start <= (state_nxt == START);
            if (take_pick) begin
                ch_sel     <= pick_ch;
                last_ch    <= pick_ch;
                settle_cnt <= SCW'(SETTLE_CYCLES - 1);
            end else if (state == SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (state == START)        conv_cnt <= '0;
            else if (state == CONVERT) conv_cnt <= conv_cnt + 1'b1;
            if (capture) pend_code <= adc_code;
            if (store_load) begin
                res_valid <= 1'b1;
                res_code  <= pend_code;
                res_ch    <= ch_sel;
            end else if (pop) begin
                res_valid <= 1'b0;
            end
            // Sticky flags: a set in the same cycle as clr_err wins
            if (state == STORE && !store_load) overrun <= 1'b1;
            else if (clr_err)                  overrun <= 1'b0;
            if (to_set)       timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Directed bench for sar_scan_sequencer with a cycle-stepped SAR core model
// (stale done outside a conversion, done at conv_cnt=2 or never in timeout mode).
module tb_sar_scan_sequencer;
    logic       clk = 1'b0;
    logic       reset_n, enable, clr_err, adc_done, res_ready;
    logic [3:0] ch_mask;
    logic [2:0] adc_code;
    logic [1:0] ch_sel, res_ch;
    logic [2:0] res_code;
    logic       sample, adc_start, res_valid, busy, overrun, timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int tnow     = 0;
    int cc       = 100;
    bit to_mode  = 1'b0;
    int exp_ch[$];

    localparam int K = 2;

    sar_scan_sequencer dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask), .clr_err(clr_err),
        .ch_sel(ch_sel), .sample(sample), .adc_start(adc_start), .adc_done(adc_done),
        .adc_code(adc_code), .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code),
        .res_ch(res_ch), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic int code_of(input int ch);
        return (2 * ch + 1) & 7;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @t=%0d: got %0d expected %0d", tag, tnow, got, exp);
        end
    endtask

    // One clock; the core model reacts to what the DUT shows after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        tnow++;
        if (adc_start) cc = -1;
        else if (cc < 100) cc++;
        if (to_mode) adc_done = (cc <= 0);
        else         adc_done = !(cc >= 1 && cc < K);
        adc_code = 3'(code_of(int'(ch_sel)));
    endtask

    task automatic adv(input int t);
        while (tnow < t) step();
    endtask

    task automatic start_e0();
        tnow   = -1;
        enable = 1'b1;
        step();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        clr_err   = 1'b0;
        res_ready = 1'b1;
        to_mode   = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        check("rst ch_sel", int'(ch_sel), 0);
        check("rst sample", int'(sample), 0);
        check("rst adc_start", int'(adc_start), 0);
        check("rst res_valid", int'(res_valid), 0);
        check("rst res_code", int'(res_code), 0);
        check("rst res_ch", int'(res_ch), 0);
        check("rst busy", int'(busy), 0);
        check("rst overrun", int'(overrun), 0);
        check("rst timeout_err", int'(timeout_err), 0);
    endtask

    // Free-running scan with res_ready=1 and k=2: 9-cycle period, result at t%9==0.
    task automatic scan(input int t_end);
        int c;
        while (tnow < t_end) begin
            step();
            check("scan res_valid", int'(res_valid), int'(tnow % 9 == 0));
            check("scan adc_start", int'(adc_start), int'(tnow % 9 == 4));
            check("scan sample", int'(sample), int'(tnow % 9 < 4));
            if (tnow % 9 == 0 && exp_ch.size() > 0) begin
                c = exp_ch.pop_front();
                check("scan res_ch", int'(res_ch), c);
                check("scan res_code", int'(res_code), code_of(c));
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; clr_err = 1'b0; res_ready = 1'b1;
        ch_mask = 4'b0000; adc_done = 1'b1; adc_code = 3'd0;

        // Full mask round robin
        do_reset();
        ch_mask = 4'b1111;
        exp_ch  = '{0, 1, 2, 3, 0};
        start_e0();
        check("e0 busy", int'(busy), 1);
        scan(45);

        // Single channel, then mask change mid-SETTLE
        do_reset();
        ch_mask = 4'b0100;
        exp_ch  = '{2, 2, 2, 3, 0, 3};
        start_e0();
        scan(19);
        ch_mask = 4'b1001;
        scan(54);

        // Consumer stalled: hold first result, overrun, set beats clear
        do_reset();
        ch_mask   = 4'b0011;
        res_ready = 1'b0;
        start_e0();
        adv(9);
        check("hold valid1", int'(res_valid), 1);
        check("hold ch1", int'(res_ch), 0);
        check("hold code1", int'(res_code), code_of(0));
        check("ovr clear1", int'(overrun), 0);
        adv(18);
        check("hold valid2", int'(res_valid), 1);
        check("hold ch2", int'(res_ch), 0);
        check("hold code2", int'(res_code), code_of(0));
        check("ovr set", int'(overrun), 1);
        adv(26);
        clr_err = 1'b1;
        adv(27);
        clr_err = 1'b0;
        check("ovr set wins", int'(overrun), 1);
        check("hold ch3", int'(res_ch), 0);
        clr_err = 1'b1;
        adv(28);
        clr_err = 1'b0;
        check("ovr cleared", int'(overrun), 0);
        res_ready = 1'b1;
        adv(29);
        check("pop valid", int'(res_valid), 0);
        adv(36);
        check("4th valid", int'(res_valid), 1);
        check("4th ch", int'(res_ch), 1);
        check("4th code", int'(res_code), code_of(1));

        // Timeout: done stuck low after blanking
        do_reset();
        ch_mask = 4'b0011;
        to_mode = 1'b1;
        start_e0();
        while (tnow < 20) begin
            step();
            check("to no valid", int'(res_valid), 0);
            check("to not yet", int'(timeout_err), 0);
        end
        adv(21);
        check("to set", int'(timeout_err), 1);
        check("to no valid", int'(res_valid), 0);
        check("to next sample", int'(sample), 1);
        check("to next ch", int'(ch_sel), 1);
        check("to busy", int'(busy), 1);
        clr_err = 1'b1;
        adv(22);
        clr_err = 1'b0;
        check("to cleared", int'(timeout_err), 0);

        // Enable dropped mid-conversion, then empty mask
        do_reset();
        ch_mask = 4'b1111;
        start_e0();
        adv(6);
        enable = 1'b0;
        adv(8);
        check("drop busy", int'(busy), 1);
        adv(9);
        check("drop valid", int'(res_valid), 1);
        check("drop ch", int'(res_ch), 0);
        check("drop code", int'(res_code), code_of(0));
        check("drop idle", int'(busy), 0);
        check("drop sample", int'(sample), 0);
        adv(12);
        check("drop popped", int'(res_valid), 0);
        check("drop still idle", int'(busy), 0);
        ch_mask = 4'b0000;
        enable  = 1'b1;
        adv(15);
        check("nomask busy", int'(busy), 0);
        check("nomask sample", int'(sample), 0);
        check("nomask start", int'(adc_start), 0);

        // Reset during CONVERT; restart picks lowest enabled channel
        ch_mask = 4'b1111;
        start_e0();
        check("pre-rst pick", int'(ch_sel), 1);
        adv(6);
        reset_n = 1'b0;
        adv(7);
        reset_n = 1'b1;
        check("mid rst ch_sel", int'(ch_sel), 0);
        check("mid rst sample", int'(sample), 0);
        check("mid rst adc_start", int'(adc_start), 0);
        check("mid rst busy", int'(busy), 0);
        check("mid rst res_valid", int'(res_valid), 0);
        adv(8);
        check("restart ch", int'(ch_sel), 0);
        check("restart sample", int'(sample), 1);
        adv(17);
        check("restart valid", int'(res_valid), 1);
        check("restart res_ch", int'(res_ch), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
